// File: rtl/braille_cell_sequencer.sv
// Steps a packed BCD word MSD-first onto a single Braille cell, with a dwell per digit and an optional blank gap.
// Leading-zero suppression, sticky invalid-digit flag, abort, and a one-cycle done pulse.
module braille_cell_sequencer #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 30,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  input  logic                    lz_en,
  input  logic                    abort,
  output logic                    ready,
  output logic                    busy,
  output logic [3:0]              bcd_out,
  output logic                    cell_valid,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] word;
  logic                    lz;
  logic [CNT_W-1:0]        cnt;

  // {cell_valid, bcd_out} for a digit; a digit is suppressed only when it and every higher digit are zero.
  function automatic logic [4:0] cell_of(input logic [4*NUM_DIGITS-1:0] w,
                                         input logic [IDX_W-1:0] idx,
                                         input logic lz_on);
    logic [3:0] d;
    logic       hi_zero;
    d       = w[4*int'(idx) +: 4];
    hi_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && w[4*i +: 4] != 4'd0) hi_zero = 1'b0;
    end
    if (d > 4'd9) return 5'd0;
    if (lz_on && idx != '0 && hi_zero) return 5'd0;
    return {1'b1, d};
  endfunction

  function automatic logic any_bad(input logic [4*NUM_DIGITS-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      lz         <= 1'b0;
      cnt        <= '0;
      digit_idx  <= '0;
      bcd_out    <= 4'd0;
      cell_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        cnt        <= '0;
        digit_idx  <= '0;
        bcd_out    <= 4'd0;
        cell_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              word                  <= in_bcd;
              lz                    <= lz_en;
              err                   <= any_bad(in_bcd);
              digit_idx             <= LAST_IDX;
              cnt                   <= '0;
              {cell_valid, bcd_out} <= cell_of(in_bcd, LAST_IDX, lz_en);
              state                 <= SHOW;
            end
          end
          SHOW: begin
            if (cnt == DWELL_LAST) begin
              cnt <= '0;
              if (digit_idx == '0) begin
                state      <= DONE;
                done       <= 1'b1;
                bcd_out    <= 4'd0;
                cell_valid <= 1'b0;
              end else begin
                digit_idx <= digit_idx - 1'b1;
                if (GAP_CYCLES == 0) begin
                  {cell_valid, bcd_out} <= cell_of(word, digit_idx - 1'b1, lz);
                end else begin
                  state      <= GAP;
                  bcd_out    <= 4'd0;
                  cell_valid <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt                   <= '0;
              state                 <= SHOW;
              {cell_valid, bcd_out} <= cell_of(word, digit_idx, lz);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state     <= IDLE;
            digit_idx <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_braille_cell_sequencer.sv
// Scoreboard bench: each accepted word pushes its per-cycle expected outputs, popped and compared every cycle.
module tb_braille_cell_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, lz_en = 1'b0, abort = 1'b0;
  logic [15:0] in_bcd = '0;
  logic        ready, busy, cell_valid, done, err;
  logic [3:0]  bcd_out;
  logic [1:0]  digit_idx;

  logic        start2 = 1'b0, lz2 = 1'b0, abort2 = 1'b0;
  logic [7:0]  in2 = '0;
  logic        ready2, busy2, cell_valid2, done2, err2;
  logic [3:0]  bcd_out2;
  logic [0:0]  digit_idx2;

  braille_cell_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_bcd(in_bcd), .lz_en(lz_en), .abort(abort),
    .ready(ready), .busy(busy), .bcd_out(bcd_out), .cell_valid(cell_valid),
    .digit_idx(digit_idx), .done(done), .err(err));

  braille_cell_sequencer #(.NUM_DIGITS(2), .DWELL_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_bcd(in2), .lz_en(lz2), .abort(abort2),
    .ready(ready2), .busy(busy2), .bcd_out(bcd_out2), .cell_valid(cell_valid2),
    .digit_idx(digit_idx2), .done(done2), .err(err2));

  typedef struct packed {
    logic       cv;
    logic [3:0] bcd;
    logic       dn;
    logic       rdy;
    logic       bsy;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic cv, input logic [3:0] bcd, input logic dn,
                              input logic rdy, input logic bsy, input logic [1:0] idx);
    exp_t e;
    e.cv = cv; e.bcd = bcd; e.dn = dn; e.rdy = rdy; e.bsy = bsy; e.idx = idx;
    return e;
  endfunction

  // Default-parameter timeline (4 digits, dwell 30, gap 2) for cycles 1 .. done+1.
  task automatic push_model(input logic [15:0] w, input logic lz);
    logic       seen;
    logic       show;
    logic [3:0] dig;
    seen = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      dig = w[4*d +: 4];
      if (dig != 4'd0) seen = 1'b1;
      show = (dig <= 4'd9) && !(lz && d != 0 && !seen);
      for (int k = 0; k < 30; k++) sb.push_back(mk(show, show ? dig : 4'd0, 1'b0, 1'b0, 1'b1, 2'(d)));
      if (d != 0)
        for (int k = 0; k < 2; k++) sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'(d - 1)));
    end
    sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0));
    sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
  endtask

  function automatic exp_t observed();
    return mk(cell_valid, bcd_out, done, ready, busy, digit_idx);
  endfunction

  task automatic test_reset();
    exp_t obs;
    rst_n = 1'b0;
    #3;
    obs = observed();
    n_checks++;
    if (obs !== mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h err=%b, expected %h err=0", obs, err, mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b/%b, expected 1/1", ready, ready2);
    end
  endtask

  task automatic test_lz_0907();
    exp_t e, obs;
    int   c;
    @(negedge clk); start = 1'b1; in_bcd = 16'h0907; lz_en = 1'b1; push_model(16'h0907, 1'b1);
    @(negedge clk); start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL lz_0907 cycle %0d: got %h expected %h", c, obs, e);
      end
      c++;
      @(negedge clk);
    end
  endtask

  task automatic test_all_zero();
    exp_t e, obs;
    int   c;
    @(negedge clk); start = 1'b1; in_bcd = 16'h0000; lz_en = 1'b1; push_model(16'h0000, 1'b1);
    @(negedge clk); start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL all_zero cycle %0d: got %h expected %h", c, obs, e);
      end
      c++;
      @(negedge clk);
    end
  endtask

  task automatic test_invalid();
    exp_t e, obs;
    int   c;
    @(negedge clk); start = 1'b1; in_bcd = 16'h12A4; lz_en = 1'b0; push_model(16'h12A4, 1'b0);
    @(negedge clk); start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observed(); n_checks++;
      if (obs !== e || err !== 1'b1) begin
        n_fail++;
        $display("FAIL invalid cycle %0d: got %h err=%b expected %h err=1", c, obs, err, e);
      end
      c++;
      @(negedge clk);
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky_after_done: got %b expected 1", err);
    end
    start = 1'b1; in_bcd = 16'h0123; lz_en = 1'b0;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    n_checks++;
    if (err !== 1'b0 || bcd_out !== 4'd0 || cell_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear_on_start: got err=%b bcd=%h cv=%b expected err=0 bcd=0 cv=1", err, bcd_out, cell_valid);
    end
    @(negedge clk); abort = 1'b0;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_cleanup_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_abort_and_ignored_start();
    exp_t e, obs;
    int   c;
    @(negedge clk); start = 1'b1; in_bcd = 16'h0907; lz_en = 1'b1; push_model(16'h0907, 1'b1);
    @(negedge clk); start = 1'b0;
    c = 1;
    while (c <= 40) begin
      e = sb.pop_front(); obs = observed(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_seq cycle %0d: got %h expected %h", c, obs, e);
      end
      start  = (c == 20);
      in_bcd = (c == 20) ? 16'h1111 : 16'h0907;
      abort  = (c == 40);
      c++;
      @(negedge clk);
    end
    sb.delete();
    abort = 1'b0;
    obs = observed(); n_checks++;
    if (obs !== mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0)) begin
      n_fail++;
      $display("FAIL abort_idle cycle 41: got %h expected %h", obs, mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_no_done +%0d: got done=%b ready=%b expected 0/1", k, done, ready);
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    for (int r = 0; r < 2; r++) begin
      k = (r == 0) ? $urandom_range(33, 62) : $urandom_range(97, 126);
      @(negedge clk); start = 1'b1; in_bcd = 16'hB907; lz_en = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (k - 1) @(negedge clk);
      n_checks++;
      if (cell_valid !== 1'b1 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got cv=%b err=%b expected 1/1", k, cell_valid, err);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (observed() !== mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset cycle %0d: got %h err=%b expected %h err=0", k, observed(), err, mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", ready, busy);
      end
    end
  endtask

  task automatic test_no_gap_small();
    exp_t e, obs;
    int   c;
    @(negedge clk); start2 = 1'b1; in2 = 8'h35; lz2 = 1'b0;
    sb.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'd1));
    sb.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 2'd0));
    sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0));
    sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    @(negedge clk); start2 = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = mk(cell_valid2, bcd_out2, done2, ready2, busy2, {1'b0, digit_idx2});
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL no_gap_small cycle %0d: got %h expected %h", c, obs, e);
      end
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lz_0907();
    test_all_zero();
    test_invalid();
    test_abort_and_ignored_start();
    test_async_reset();
    test_no_gap_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
